// File: rtl/post_spike_aer_encoder.sv
// Serializes post-neuron spike vectors into AER words, inserts time-step markers, buffers them in a FWFT FIFO.
// Strobe-to-valid latency is 2 cycles; a full FIFO stalls the serializer, and strobes or markers arriving while busy are dropped and flagged.
module post_spike_aer_encoder #(
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_ADDR_WIDTH      = 10,
  parameter int POST_NEUR_BYTE_ADDR_WIDTH = 2,
  parameter int AER_WIDTH                 = 12,
  parameter int FIFO_DEPTH                = 16,
  parameter int FIFO_PTR_WIDTH            = 4
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            EVT_VALID,
  input  logic [POST_NEUR_PARALLEL-1:0]   EVT_BITS,
  input  logic [POST_NEUR_ADDR_WIDTH-1:0] EVT_BASE_ADDR,
  input  logic                            TSTEP_EVENT,
  input  logic                            CLR_OVF,
  output logic                            IN_READY,
  output logic [AER_WIDTH-1:0]            AER_ADDR,
  output logic                            AER_VALID,
  input  logic                            AER_READY,
  output logic [FIFO_PTR_WIDTH:0]         FIFO_COUNT,
  output logic                            OVERFLOW
);

  localparam int PW = FIFO_PTR_WIDTH;
  localparam int AW = POST_NEUR_ADDR_WIDTH;
  localparam int BW = POST_NEUR_BYTE_ADDR_WIDTH;
  localparam logic [PW:0]   DEPTH_L    = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(POST_NEUR_PARALLEL - 1));
  localparam logic [POST_NEUR_PARALLEL-1:0] BIT_ONE = POST_NEUR_PARALLEL'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SER = 2'd1, MARK = 2'd2} state_t;

  state_t                        state, state_nxt;
  logic [POST_NEUR_PARALLEL-1:0] pend_bits;
  logic [AW-1:0]                 base;
  logic                          mark_pend;
  logic [AER_WIDTH-2:0]          tstep_idx;
  logic                          overflow;

  logic [AER_WIDTH-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [PW:0]                   count;
  logic                          full, empty, push, pop;
  logic [AER_WIDTH-1:0]          push_dat;

  logic [BW-1:0]                 low_idx;
  logic [POST_NEUR_PARALLEL-1:0] low_mask;
  logic                          last_bit;
  logic                          tstep_set;
  logic                          drop_evt;

  assign full      = (count == DEPTH_L);
  assign empty     = (count == '0);
  assign pop       = AER_READY && !empty;
  assign low_mask  = pend_bits & (~pend_bits + BIT_ONE);
  assign last_bit  = ((pend_bits & ~low_mask) == '0);
  assign tstep_set = TSTEP_EVENT && !mark_pend;
  assign drop_evt  = EVT_VALID && (state != IDLE);

  // Descending scan so the lowest set bit is the final assignment.
  always_comb begin
    low_idx = '0;
    for (int i = POST_NEUR_PARALLEL - 1; i >= 0; i--) begin
      if (pend_bits[i]) low_idx = BW'(i);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (EVT_VALID && (EVT_BITS != '0))   state_nxt = SER;
        else if (TSTEP_EVENT || mark_pend)   state_nxt = MARK;
      end
      SER: begin
        if (!full && last_bit) state_nxt = (mark_pend || tstep_set) ? MARK : IDLE;
      end
      MARK: begin
        if (!full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    push_dat = '0;
    case (state)
      SER: begin
        if (!full) begin
          push     = 1'b1;
          push_dat = AER_WIDTH'(base | AW'(low_idx));
        end
      end
      MARK: begin
        if (!full) begin
          push     = 1'b1;
          push_dat = {1'b1, tstep_idx};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_bits <= '0;
      base      <= '0;
      mark_pend <= 1'b0;
      tstep_idx <= '0;
      overflow  <= 1'b0;
    end else begin
      if (state == IDLE && EVT_VALID) begin
        pend_bits <= EVT_BITS;
        base      <= EVT_BASE_ADDR & ALIGN_MASK;
      end else if (state == SER && !full) begin
        pend_bits <= pend_bits & ~low_mask;
      end
      if (tstep_set) mark_pend <= 1'b1;
      else if (state == MARK && !full) mark_pend <= 1'b0;
      if (state == MARK && !full) tstep_idx <= tstep_idx + 1'b1;
      // A new loss in the same cycle as a clear keeps the flag set.
      if (drop_evt || (TSTEP_EVENT && mark_pend)) overflow <= 1'b1;
      else if (CLR_OVF)                           overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign IN_READY   = (state == IDLE);
  assign AER_VALID  = !empty;
  assign AER_ADDR   = empty ? '0 : mem[rd_ptr];
  assign FIFO_COUNT = count;
  assign OVERFLOW   = overflow;

endmodule

// File: tb/tb_post_spike_aer_encoder.sv
// Directed bench for post_spike_aer_encoder: inputs driven and outputs sampled on the falling clock edge.
module tb_post_spike_aer_encoder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EVT_VALID = 1'b0;
  logic [3:0]  EVT_BITS = '0;
  logic [9:0]  EVT_BASE_ADDR = '0;
  logic        TSTEP_EVENT = 1'b0;
  logic        CLR_OVF = 1'b0;
  logic        IN_READY;
  logic [11:0] AER_ADDR;
  logic        AER_VALID;
  logic        AER_READY = 1'b0;
  logic [4:0]  FIFO_COUNT;
  logic        OVERFLOW;

  int n_vec = 0;
  int n_err = 0;

  post_spike_aer_encoder dut (
    .CLK(CLK), .RST_N(RST_N), .EVT_VALID(EVT_VALID), .EVT_BITS(EVT_BITS),
    .EVT_BASE_ADDR(EVT_BASE_ADDR), .TSTEP_EVENT(TSTEP_EVENT), .CLR_OVF(CLR_OVF),
    .IN_READY(IN_READY), .AER_ADDR(AER_ADDR), .AER_VALID(AER_VALID),
    .AER_READY(AER_READY), .FIFO_COUNT(FIFO_COUNT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  // Drive a one-cycle strobe; returns at the negedge after the sampling edge.
  task automatic send(input logic [3:0] bits, input logic [9:0] addr, input logic ts);
    @(negedge CLK);
    EVT_VALID = 1'b1; EVT_BITS = bits; EVT_BASE_ADDR = addr; TSTEP_EVENT = ts;
    @(negedge CLK);
    EVT_VALID = 1'b0; EVT_BITS = '0; EVT_BASE_ADDR = '0; TSTEP_EVENT = 1'b0;
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 60 && IN_READY !== 1'b1; c++) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_vec++; if (IN_READY !== 1'b1)    begin n_err++; $display("FAIL rst_in_ready: got %b want 1", IN_READY); end
    n_vec++; if (AER_VALID !== 1'b0)   begin n_err++; $display("FAIL rst_aer_valid: got %b want 0", AER_VALID); end
    n_vec++; if (AER_ADDR !== 12'h000) begin n_err++; $display("FAIL rst_aer_addr: got %h want 000", AER_ADDR); end
    n_vec++; if (FIFO_COUNT !== 5'd0)  begin n_err++; $display("FAIL rst_count: got %0d want 0", FIFO_COUNT); end
    n_vec++; if (OVERFLOW !== 1'b0)    begin n_err++; $display("FAIL rst_overflow: got %b want 0", OVERFLOW); end
    RST_N = 1'b1;
    AER_READY = 1'b1;
  endtask

  task automatic test_serialize();
    send(4'b1011, 10'h0A7, 1'b0);
    n_vec++; if (IN_READY !== 1'b0)  begin n_err++; $display("FAIL ser_rdy_c1: got %b want 0", IN_READY); end
    n_vec++; if (AER_VALID !== 1'b0) begin n_err++; $display("FAIL ser_valid_c1: got %b want 0", AER_VALID); end
    @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b1 || AER_ADDR !== 12'h0A4) begin n_err++; $display("FAIL ser_w0: got v=%b %h want v=1 0a4", AER_VALID, AER_ADDR); end
    n_vec++; if (IN_READY !== 1'b0)  begin n_err++; $display("FAIL ser_rdy_c2: got %b want 0", IN_READY); end
    @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b1 || AER_ADDR !== 12'h0A5) begin n_err++; $display("FAIL ser_w1: got v=%b %h want v=1 0a5", AER_VALID, AER_ADDR); end
    n_vec++; if (IN_READY !== 1'b0)  begin n_err++; $display("FAIL ser_rdy_c3: got %b want 0", IN_READY); end
    @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b1 || AER_ADDR !== 12'h0A7) begin n_err++; $display("FAIL ser_w2: got v=%b %h want v=1 0a7", AER_VALID, AER_ADDR); end
    n_vec++; if (IN_READY !== 1'b1)  begin n_err++; $display("FAIL ser_rdy_c4: got %b want 1", IN_READY); end
    @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b0 || FIFO_COUNT !== 5'd0) begin n_err++; $display("FAIL ser_empty: got v=%b cnt=%0d want v=0 cnt=0", AER_VALID, FIFO_COUNT); end
  endtask

  task automatic test_marker();
    send(4'b0001, 10'h010, 1'b1);
    n_vec++; if (AER_VALID !== 1'b0) begin n_err++; $display("FAIL mk_valid_c1: got %b want 0", AER_VALID); end
    @(negedge CLK);
    n_vec++; if (AER_ADDR !== 12'h010) begin n_err++; $display("FAIL mk_spike: got %h want 010", AER_ADDR); end
    @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b1 || AER_ADDR !== 12'h800) begin n_err++; $display("FAIL mk_first: got v=%b %h want v=1 800", AER_VALID, AER_ADDR); end
    n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL mk_rdy: got %b want 1", IN_READY); end
    @(negedge CLK);
    TSTEP_EVENT = 1'b1;
    @(negedge CLK);
    TSTEP_EVENT = 1'b0;
    n_vec++; if (AER_VALID !== 1'b0) begin n_err++; $display("FAIL mk_gap: got %b want 0", AER_VALID); end
    @(negedge CLK);
    n_vec++; if (AER_ADDR !== 12'h801) begin n_err++; $display("FAIL mk_second: got %h want 801", AER_ADDR); end
    for (int k = 0; k < 2046; k++) begin
      @(negedge CLK); TSTEP_EVENT = 1'b1;
      @(negedge CLK); TSTEP_EVENT = 1'b0;
    end
    @(negedge CLK);
    TSTEP_EVENT = 1'b1;
    n_vec++; if (AER_VALID !== 1'b1 || AER_ADDR !== 12'hFFF) begin n_err++; $display("FAIL mk_last_idx: got v=%b %h want v=1 fff", AER_VALID, AER_ADDR); end
    @(negedge CLK);
    TSTEP_EVENT = 1'b0;
    @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b1 || AER_ADDR !== 12'h800) begin n_err++; $display("FAIL mk_wrap: got v=%b %h want v=1 800", AER_VALID, AER_ADDR); end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    int got;
    AER_READY = 1'b0;
    for (int s = 0; s < 5; s++) begin
      wait_ready();
      n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_ready_wait%0d: got %b want 1", s, IN_READY); end
      send(4'b1111, 10'h100 + 10'(4 * s), 1'b0);
    end
    repeat (8) @(negedge CLK);
    n_vec++; if (FIFO_COUNT !== 5'd16) begin n_err++; $display("FAIL bp_count: got %0d want 16", FIFO_COUNT); end
    n_vec++; if (IN_READY !== 1'b0)    begin n_err++; $display("FAIL bp_stall: got %b want 0", IN_READY); end
    n_vec++; if (AER_ADDR !== 12'h100) begin n_err++; $display("FAIL bp_head: got %h want 100", AER_ADDR); end
    AER_READY = 1'b1;
    got = 0;
    for (int c = 0; c < 80 && got < 20; c++) begin
      if (AER_VALID === 1'b1) begin
        n_vec++; if (AER_ADDR !== 12'h100 + 12'(got)) begin n_err++; $display("FAIL bp_word%0d: got %h want %h", got, AER_ADDR, 12'h100 + 12'(got)); end
        got++;
      end
      @(negedge CLK);
    end
    n_vec++; if (got !== 20) begin n_err++; $display("FAIL bp_total: got %0d want 20", got); end
    repeat (3) @(negedge CLK);
    n_vec++; if (FIFO_COUNT !== 5'd0 || IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_drained: got cnt=%0d rdy=%b want cnt=0 rdy=1", FIFO_COUNT, IN_READY); end
  endtask

  task automatic test_overflow();
    int got;
    @(negedge CLK);
    EVT_VALID = 1'b1; EVT_BITS = 4'b1111; EVT_BASE_ADDR = 10'h200;
    @(negedge CLK);
    EVT_BITS = 4'b0001; EVT_BASE_ADDR = 10'h300;
    @(negedge CLK);
    EVT_VALID = 1'b0; EVT_BITS = '0; EVT_BASE_ADDR = '0;
    n_vec++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", OVERFLOW); end
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (AER_VALID === 1'b1) got++;
      @(negedge CLK);
    end
    n_vec++; if (got !== 4)         begin n_err++; $display("FAIL ovf_words: got %0d want 4", got); end
    n_vec++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); end
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
    n_vec++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", OVERFLOW); end
    EVT_VALID = 1'b1; EVT_BITS = 4'b1111; EVT_BASE_ADDR = 10'h200;
    @(negedge CLK);
    CLR_OVF = 1'b1;
    @(negedge CLK);
    EVT_VALID = 1'b0; EVT_BITS = '0; EVT_BASE_ADDR = '0; CLR_OVF = 1'b0;
    n_vec++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", OVERFLOW); end
    repeat (8) @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got %b want 0", AER_VALID); end
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
  endtask

  task automatic test_full_tstep();
    int got;
    logic [11:0] exp;
    AER_READY = 1'b0;
    for (int s = 0; s < 4; s++) begin
      wait_ready();
      n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL ft_ready_wait%0d: got %b want 1", s, IN_READY); end
      send(4'b1111, 10'h040 + 10'(4 * s), 1'b0);
    end
    wait_ready();
    n_vec++; if (FIFO_COUNT !== 5'd16 || IN_READY !== 1'b1) begin n_err++; $display("FAIL ft_full: got cnt=%0d rdy=%b want cnt=16 rdy=1", FIFO_COUNT, IN_READY); end
    @(negedge CLK); TSTEP_EVENT = 1'b1;
    @(negedge CLK); TSTEP_EVENT = 1'b0;
    n_vec++; if (OVERFLOW !== 1'b0 || IN_READY !== 1'b0) begin n_err++; $display("FAIL ft_first_ts: got ovf=%b rdy=%b want ovf=0 rdy=0", OVERFLOW, IN_READY); end
    @(negedge CLK); TSTEP_EVENT = 1'b1;
    @(negedge CLK); TSTEP_EVENT = 1'b0;
    n_vec++; if (OVERFLOW !== 1'b1 || FIFO_COUNT !== 5'd16) begin n_err++; $display("FAIL ft_second_ts: got ovf=%b cnt=%0d want ovf=1 cnt=16", OVERFLOW, FIFO_COUNT); end
    AER_READY = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (AER_VALID === 1'b1) begin
        exp = (got < 16) ? 12'h040 + 12'(got) : 12'h801;
        n_vec++; if (AER_ADDR !== exp) begin n_err++; $display("FAIL ft_word%0d: got %h want %h", got, AER_ADDR, exp); end
        got++;
      end
      @(negedge CLK);
    end
    n_vec++; if (got !== 17) begin n_err++; $display("FAIL ft_total: got %0d want 17", got); end
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
  endtask

  task automatic test_zero_bits();
    send(4'b0000, 10'h123, 1'b0);
    n_vec++; if (IN_READY !== 1'b1 || AER_VALID !== 1'b0) begin n_err++; $display("FAIL zb_c1: got rdy=%b v=%b want rdy=1 v=0", IN_READY, AER_VALID); end
    @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b0 || FIFO_COUNT !== 5'd0) begin n_err++; $display("FAIL zb_c2: got v=%b cnt=%0d want v=0 cnt=0", AER_VALID, FIFO_COUNT); end
  endtask

  task automatic test_reset_mid();
    AER_READY = 1'b0;
    send(4'b1111, 10'h080, 1'b0);
    @(negedge CLK);
    n_vec++; if (FIFO_COUNT !== 5'd1 || IN_READY !== 1'b0) begin n_err++; $display("FAIL rm_pre: got cnt=%0d rdy=%b want cnt=1 rdy=0", FIFO_COUNT, IN_READY); end
    #2 RST_N = 1'b0;
    #1;
    n_vec++; if (IN_READY !== 1'b1 || AER_VALID !== 1'b0 || AER_ADDR !== 12'h000 || FIFO_COUNT !== 5'd0 || OVERFLOW !== 1'b0) begin
      n_err++; $display("FAIL rm_async: got rdy=%b v=%b a=%h cnt=%0d ovf=%b want 1 0 000 0 0", IN_READY, AER_VALID, AER_ADDR, FIFO_COUNT, OVERFLOW);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    AER_READY = 1'b1;
    repeat (6) @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b0 || FIFO_COUNT !== 5'd0 || IN_READY !== 1'b1) begin n_err++; $display("FAIL rm_residual: got v=%b cnt=%0d rdy=%b want 0 0 1", AER_VALID, FIFO_COUNT, IN_READY); end
    TSTEP_EVENT = 1'b1;
    @(negedge CLK);
    TSTEP_EVENT = 1'b0;
    @(negedge CLK);
    n_vec++; if (AER_VALID !== 1'b1 || AER_ADDR !== 12'h800) begin n_err++; $display("FAIL rm_idx_reset: got v=%b %h want v=1 800", AER_VALID, AER_ADDR); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_serialize();
    test_marker();
    test_backpressure();
    test_overflow();
    test_full_tstep();
    test_zero_bits();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/post_spike_aer_encoder.md
# post_spike_aer_encoder

Downstream of the post-synaptic neuron core. It takes the `POST_NEUR_PARALLEL`-wide spike vector produced for one post-neuron SRAM word and serializes it into one AER address per spike. It also inserts a time-step marker word when a time step closes, and buffers everything in a first-word-fall-through FIFO. The output side uses a valid/ready handshake towards the output AER/SPI interface.

## Interface
- `POST_NEUR_PARALLEL`, 4: spike bits delivered per input strobe.
- `POST_NEUR_ADDR_WIDTH`, 10: post-neuron address width.
- `POST_NEUR_BYTE_ADDR_WIDTH`, 2: log2(`POST_NEUR_PARALLEL`); these low address bits are ignored on input.
- `AER_WIDTH`, 12: output word width; must be ≥ `POST_NEUR_ADDR_WIDTH`+2.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `FIFO_PTR_WIDTH`, 4: log2(`FIFO_DEPTH`).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `EVT_VALID` in 1: strobe; `EVT_BITS`/`EVT_BASE_ADDR` valid this cycle.
- `EVT_BITS` in `POST_NEUR_PARALLEL`: spike vector; bit i = neuron base+i.
- `EVT_BASE_ADDR` in `POST_NEUR_ADDR_WIDTH`: neuron address of bit 0; low `POST_NEUR_BYTE_ADDR_WIDTH` bits ignored (forced 0).
- `TSTEP_EVENT` in 1: one-cycle pulse, end of time step.
- `CLR_OVF` in 1: clears `OVERFLOW`.
- `IN_READY` out 1: serializer idle, so a strobe will be accepted.
- `AER_ADDR` out `AER_WIDTH`: FIFO head word.
- `AER_VALID` out 1: FIFO not empty.
- `AER_READY` in 1: consumer accepts head when `AER_VALID`&`AER_READY`.
- `FIFO_COUNT` out `FIFO_PTR_WIDTH`+1: occupancy, 0..`FIFO_DEPTH`.
- `OVERFLOW` out 1: sticky; input strobe or marker lost.

## Operation
Word format:
- Spike word: MSB=0, bit `AER_WIDTH`-2 = 0, low `POST_NEUR_ADDR_WIDTH` bits = neuron address, other bits 0.
- Marker word: MSB=1, low `AER_WIDTH`-1 bits = time-step index (wraps mod 2^(`AER_WIDTH`-1)). The index starts at 0 and increments after each marker is enqueued.

States:
- IDLE: `IN_READY`=1. When `EVT_VALID`=1 and `EVT_BITS`≠0, capture the bits into `pend_bits` and the aligned base into `base`, then go to SER. When `EVT_BITS`=0, accept and discard; stay IDLE.
- SER: each cycle the FIFO is not full, write the spike word for the lowest set bit of `pend_bits` (address = `base`+index) and clear that bit. When the last bit is written, go to MARK if `mark_pend`=1, else IDLE. If the FIFO is full, hold; no spike is ever dropped inside the block.
- MARK: when the FIFO is not full, write the marker word, clear `mark_pend`, increment the index, then go to IDLE.

Marker and overflow rules:
- In IDLE with `pend_bits` empty, a `TSTEP_EVENT` sets `mark_pend`. If the FIFO is not full, the marker is written next cycle through MARK.
- A `TSTEP_EVENT` together with `EVT_VALID` in IDLE: spikes are enqueued first, then the marker.
- `TSTEP_EVENT` while `mark_pend`=1 already: the marker is lost and `OVERFLOW` is set.
- `EVT_VALID` while `IN_READY`=0: the strobe is dropped and `OVERFLOW` is set.
- `CLR_OVF` clears `OVERFLOW`. A set condition in the same cycle wins.

FIFO:
- Simultaneous write and pop: both happen and the count is unchanged.
- Pop is ignored when empty.
- Write is only attempted when not full.
- Pointers wrap at `FIFO_DEPTH`.

## Timing
- Reset values: `IN_READY`=1, `AER_VALID`=0, `AER_ADDR`=0, `FIFO_COUNT`=0, `OVERFLOW`=0. Also cleared: FSM=IDLE, `mark_pend`=0, time-step index=0, pointers=0.
- Reset asserted mid-serialization discards all pending spikes and FIFO contents immediately.
- Strobe sampled at edge E0: first FIFO write at E1. `AER_VALID`=1 after E1 (2-cycle latency from strobe cycle to valid).
- With the FIFO never full and `AER_READY`=1, n set bits produce n words on n consecutive cycles.
- `IN_READY` is low from E0 until the edge that writes the last spike (or marker). It is high in the cycle after that edge.
- `AER_ADDR`/`AER_VALID` are FWFT: the head is visible combinationally from FIFO storage and stable until popped.

## Test plan
- Reset, then strobe `EVT_BITS`=4'b1011, base=0x0A7 (aligned to 0x0A4) → words 0x0A4, 0x0A5, 0x0A7 on consecutive cycles; `AER_VALID` rises 2 cycles after the strobe; `IN_READY` is low for 3 cycles.
- `TSTEP_EVENT` with `EVT_VALID`, `EVT_BITS`=4'b0001, base=0x010 → 0x010 then 0x800. The next time step gives 0x801. After 2^11 markers the index wraps to 0x800.
- `AER_READY`=0, strobe 4'b1111 five times (waiting on `IN_READY`) → `FIFO_COUNT`=16, serializer stalls with `IN_READY`=0, no word lost; releasing `AER_READY` drains all 20 words in order.
- Strobe while `IN_READY`=0 → strobe dropped, `OVERFLOW`=1 and sticky; `CLR_OVF` → 0; `CLR_OVF` in the same cycle as a new drop → stays 1.
- Two `TSTEP_EVENT`s while the FIFO is full → only one marker enqueued, `OVERFLOW`=1.
- `EVT_BITS`=0 strobe → no output, `IN_READY` stays 1. Assert `RST_N` low during SER → all outputs at reset values asynchronously; no residual words after release.
